// File: rtl/ysyx_23060229_lsu_pkg.sv
// rtl/ysyx_23060229_lsu_pkg.sv - shared quest encodings, LSU states and alignment helper
package ysyx_23060229_lsu_pkg;

  localparam logic [1:0] QUEST_NONE = 2'b00;
  localparam logic [1:0] QUEST_BYTE = 2'b01;
  localparam logic [1:0] QUEST_HALF = 2'b10;
  localparam logic [1:0] QUEST_WORD = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      QUEST_HALF: bad = offset[0];
      QUEST_WORD: bad = (offset != 2'b00);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_23060229_lsu_align.sv
// rtl/ysyx_23060229_lsu_align.sv - byte-lane steering for stores and extraction/extension for loads
module ysyx_23060229_lsu_align
  import ysyx_23060229_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        ld_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic        sign_fill;

  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = 32'h0;
    ld_data    = 32'h0;
    sign_fill  = 1'b0;
    shifted    = word >> {offset, 3'b000};
    case (size)
      QUEST_BYTE: begin
        wmask      = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        sign_fill  = ~ld_unsigned & shifted[7];
        ld_data    = {{24{sign_fill}}, shifted[7:0]};
      end
      QUEST_HALF: begin
        wmask      = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
        sign_fill  = ~ld_unsigned & shifted[15];
        ld_data    = {{16{sign_fill}}, shifted[15:0]};
      end
      QUEST_WORD: begin
        wmask      = 4'b1111;
        wdata_lane = wdata;
        ld_data    = shifted;
      end
      default: begin
        wmask      = 4'b0000;
        wdata_lane = 32'h0;
        ld_data    = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060229_lsu.sv
// rtl/ysyx_23060229_lsu.sv - single-outstanding load/store unit between EXU and the data-memory port
module ysyx_23060229_lsu
  import ysyx_23060229_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        rd_quest,
  input  logic [1:0]        wr_quest,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  lsu_state_e state, next_state;

  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;

  logic [1:0]  req_size;
  logic        has_rd, has_wr;
  logic        req_bad, req_noop;
  logic        accept, start_bus;

  logic [1:0]  sel_size;
  logic [1:0]  sel_off;
  logic        sel_uns;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] ext_data;

  assign has_rd    = (rd_quest != QUEST_NONE);
  assign has_wr    = (wr_quest != QUEST_NONE);
  assign req_size  = rd_quest | wr_quest;
  assign req_noop  = ~has_rd & ~has_wr;
  assign req_bad   = (has_rd & has_wr) | is_misaligned(req_size, addr[1:0]);
  assign accept    = (state == LSU_IDLE) & req_valid;
  assign start_bus = accept & ~req_bad & ~req_noop;

  // The aligner is shared: it steers incoming store data while idle and extracts
  // load data from the latched request once the bus transaction is underway.
  assign sel_size = (state == LSU_IDLE) ? req_size    : size_q;
  assign sel_off  = (state == LSU_IDLE) ? addr[1:0]   : off_q;
  assign sel_uns  = (state == LSU_IDLE) ? ld_unsigned : uns_q;

  ysyx_23060229_lsu_align u_align (
    .size        (sel_size),
    .offset      (sel_off),
    .ld_unsigned (sel_uns),
    .wdata       (wdata),
    .word        (mem_rdata),
    .wmask       (lane_mask),
    .wdata_lane  (lane_wdata),
    .ld_data     (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LSU_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    done          = 1'b0;
    case (state)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = start_bus ? LSU_REQ : LSU_DONE;
        end
      end
      LSU_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          next_state = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (mem_resp_valid) begin
          next_state = LSU_DONE;
        end
      end
      LSU_DONE: begin
        done       = 1'b1;
        next_state = LSU_IDLE;
      end
      default: next_state = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q    <= QUEST_NONE;
      off_q     <= 2'b00;
      uns_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= 4'b0000;
      mem_wdata <= '0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        err   <= req_bad;
        rdata <= '0;
        if (start_bus) begin
          size_q    <= req_size;
          off_q     <= addr[1:0];
          uns_q     <= ld_unsigned;
          mem_we    <= has_wr;
          mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
          mem_wmask <= has_wr ? lane_mask  : 4'b0000;
          mem_wdata <= has_wr ? lane_wdata : '0;
        end
      end else if ((state == LSU_WAIT) && mem_resp_valid && !mem_we) begin
        rdata <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060229_lsu.sv
// tb/tb_ysyx_23060229_lsu.sv - vector table, corner sequences and randomized model check for the LSU
module tb_ysyx_23060229_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  rd_quest;
  logic [1:0]  wr_quest;
  logic        ld_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  ysyx_23060229_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .rd_quest       (rd_quest),
    .wr_quest       (wr_quest),
    .ld_unsigned    (ld_unsigned),
    .addr           (addr),
    .wdata          (wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wmask      (mem_wmask),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .done           (done),
    .err            (err),
    .rdata          (rdata)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        err;
    logic        bus;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  mask;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic        bus;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  mask;
    logic [31:0] mwdata;
    int          unstable;
    int          rr_bad;
    logic        done_after;
    logic        rr_after;
  } obs_t;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          rdly;
    int          wdly;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] mwdata;
    logic [31:0] maddr;
    int          lat;
  } vec_t;

  obs_t obs;
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: derived from size in bytes and byte offset with plain arithmetic.
  function automatic exp_t model(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                                 input int rdly, input int wdly);
    exp_t e;
    int q, n, off;
    logic [31:0] v, m;
    e = '{default: 0};
    e.lat = 1;
    off = int'(a[1:0]);
    q = (rd != 0) ? int'(rd) : int'(wr);
    if (rd != 0 && wr != 0) begin e.err = 1'b1; return e; end
    if (q == 0) return e;
    n = 1 << (q - 1);
    if (off % n != 0) begin e.err = 1'b1; return e; end
    e.bus   = 1'b1;
    e.we    = (wr != 0);
    e.maddr = a - off;
    e.lat   = 3 + rdly + wdly;
    if (e.we) begin
      for (int b = 0; b < n; b++) e.mask[off + b] = 1'b1;
      for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = wd[8*(i % n) +: 8];
    end else begin
      v = rw >> (8 * off);
      m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v = v & m;
      if (!uns && v[8*n-1]) v = v | ~m;
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic run_txn(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                         input int rdly, input int wdly);
    int rc, wc;
    logic in_wait;
    @(negedge clk);
    req_valid = 1'b1; rd_quest = rd; wr_quest = wr; ld_unsigned = uns; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; rd_quest = 2'b00; wr_quest = 2'b00; addr = $urandom; wdata = $urandom;
    obs = '{default: 0};
    obs.lat = -1;
    rc = 0; wc = 0; in_wait = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
      if (req_ready) obs.rr_bad++;
      if (done) begin
        obs.lat = k; obs.err = err; obs.rdata = rdata;
        break;
      end
      if (mem_req_valid) begin
        if (!obs.bus) begin
          obs.bus = 1'b1; obs.we = mem_we; obs.maddr = mem_addr;
          obs.mask = mem_wmask; obs.mwdata = mem_wdata;
        end else if (mem_we !== obs.we || mem_addr !== obs.maddr ||
                     mem_wmask !== obs.mask || mem_wdata !== obs.mwdata) begin
          obs.unstable++;
        end
        if (rc >= rdly) begin
          mem_req_ready = 1'b1;
          in_wait = 1'b1;
        end else begin
          mem_resp_valid = 1'b1;  // stray response while not yet accepted
        end
        rc++;
      end else if (in_wait) begin
        if (wc >= wdly) begin
          mem_resp_valid = 1'b1;
          mem_rdata = rw;
        end
        wc++;
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    obs.done_after = done;
    obs.rr_after   = req_ready;
  endtask

  task automatic verify(input string tag, input exp_t e);
    check({tag, ".latency"}, obs.lat, e.lat);
    check({tag, ".err"}, obs.err, e.err);
    check({tag, ".rdata"}, obs.rdata, e.rdata);
    check({tag, ".bus_seen"}, obs.bus, e.bus);
    if (e.bus) begin
      check({tag, ".mem_we"}, obs.we, e.we);
      check({tag, ".mem_addr"}, obs.maddr, e.maddr);
      check({tag, ".mem_wmask"}, obs.mask, e.mask);
      if (e.we) check({tag, ".mem_wdata"}, obs.mwdata, e.mwdata);
      check({tag, ".mem_stable"}, obs.unstable, 0);
    end
    check({tag, ".req_ready_low"}, obs.rr_bad, 0);
    check({tag, ".single_done"}, obs.done_after, 1'b0);
    check({tag, ".req_ready_back"}, obs.rr_after, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".req_ready"}, req_ready, 1'b1);
    check({tag, ".mem_req_valid"}, mem_req_valid, 1'b0);
    check({tag, ".mem_we"}, mem_we, 1'b0);
    check({tag, ".mem_addr"}, mem_addr, 32'h0);
    check({tag, ".mem_wmask"}, mem_wmask, 4'h0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".err"}, err, 1'b0);
    check({tag, ".rdata"}, rdata, 32'h0);
  endtask

  initial begin
    exp_t e;
    logic [1:0] rd, wr;
    int sel;

    vecs[0]  = '{2'd0, 2'd3, 1'b0, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 32'h8000_0008, 3};
    vecs[1]  = '{2'd0, 2'd1, 1'b0, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 32'h0, 4'h8, 32'hA5A5_A5A5, 32'h8000_0000, 3};
    vecs[2]  = '{2'd1, 2'd0, 1'b0, 32'h8000_0002, 32'h0, 32'h12F0_3456, 0, 0, 1'b0, 32'hFFFF_FFF0, 4'h0, 32'h0, 32'h8000_0000, 3};
    vecs[3]  = '{2'd1, 2'd0, 1'b1, 32'h8000_0002, 32'h0, 32'h12F0_3456, 0, 0, 1'b0, 32'h0000_00F0, 4'h0, 32'h0, 32'h8000_0000, 3};
    vecs[4]  = '{2'd2, 2'd0, 1'b0, 32'h8000_0000, 32'h0, 32'h12F0_3456, 0, 0, 1'b0, 32'h0000_3456, 4'h0, 32'h0, 32'h8000_0000, 3};
    vecs[5]  = '{2'd2, 2'd0, 1'b0, 32'h8000_0002, 32'h0, 32'h8000_1234, 5, 3, 1'b0, 32'hFFFF_8000, 4'h0, 32'h0, 32'h8000_0000, 11};
    vecs[6]  = '{2'd3, 2'd0, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 1};
    vecs[7]  = '{2'd3, 2'd1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 1};
    vecs[8]  = '{2'd0, 2'd0, 1'b0, 32'h8000_0001, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1};
    vecs[9]  = '{2'd0, 2'd2, 1'b0, 32'h8000_0006, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0, 32'h0, 4'hC, 32'hABCD_ABCD, 32'h8000_0004, 3};
    vecs[10] = '{2'd3, 2'd0, 1'b0, 32'h8000_0010, 32'h0, 32'h8765_4321, 0, 0, 1'b0, 32'h8765_4321, 4'h0, 32'h0, 32'h8000_0010, 3};
    vecs[11] = '{2'd0, 2'd2, 1'b0, 32'h8000_0001, 32'h0000_BEEF, 32'h0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 1};
    vecs[12] = '{2'd0, 2'd1, 1'b0, 32'h8000_0001, 32'h0000_005A, 32'h0, 2, 1, 1'b0, 32'h0, 4'h2, 32'h5A5A_5A5A, 32'h8000_0000, 6};
    vecs[13] = '{2'd2, 2'd0, 1'b1, 32'h8000_0002, 32'h0, 32'hFEDC_0000, 0, 0, 1'b0, 32'h0000_FEDC, 4'h0, 32'h0, 32'h8000_0000, 3};

    rst = 1'b1; req_valid = 1'b0; rd_quest = 2'b00; wr_quest = 2'b00; ld_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      e.err    = vecs[i].err;
      e.bus    = (vecs[i].lat > 1);
      e.we     = e.bus && (vecs[i].wr != 2'd0);
      e.maddr  = vecs[i].maddr;
      e.mask   = vecs[i].mask;
      e.mwdata = vecs[i].mwdata;
      e.rdata  = vecs[i].rdata;
      e.lat    = vecs[i].lat;
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              vecs[i].rword, vecs[i].rdly, vecs[i].wdly);
      verify($sformatf("vec%0d", i), e);
    end

    // Reset while waiting for the response: the late response must be ignored.
    @(negedge clk);
    req_valid = 1'b1; rd_quest = 2'd3; addr = 32'h8000_0000;
    @(negedge clk);
    req_valid = 1'b0; rd_quest = 2'd0;
    check("rstwait.mem_req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rstwait.in_wait", {mem_req_valid, req_ready, done}, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    check_reset("rstwait");
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("rstwait.no_done", done, 1'b0);
    check("rstwait.idle", req_ready, 1'b1);
    check("rstwait.rdata", rdata, 32'h0);
    e = model(2'd3, 2'd0, 1'b0, 32'h8000_0004, 32'h0, 32'h1357_9BDF, 0, 0);
    run_txn(2'd3, 2'd0, 1'b0, 32'h8000_0004, 32'h0, 32'h1357_9BDF, 0, 0);
    verify("after_rst", e);

    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      rd = 2'd0; wr = 2'd0;
      if (sel < 4)       rd = 2'($urandom_range(1, 3));
      else if (sel < 8)  wr = 2'($urandom_range(1, 3));
      else if (sel == 8) begin rd = 2'($urandom_range(1, 3)); wr = 2'($urandom_range(1, 3)); end
      begin
        logic [31:0] a, wd, rw;
        logic u;
        int rdly, wdly;
        a = $urandom; wd = $urandom; rw = $urandom; u = 1'($urandom_range(0, 1));
        rdly = $urandom_range(0, 3); wdly = $urandom_range(0, 3);
        e = model(rd, wr, u, a, wd, rw, rdly, wdly);
        run_txn(rd, wr, u, a, wd, rw, rdly, wdly);
        verify($sformatf("rand%0d", t), e);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
